// File: rtl/ahb_bus_mux_ctrl_if.sv
// rtl/ahb_bus_mux_ctrl_if.sv - AHB-Lite shared-bus signal bundle between masters, slaves and the mux controller
interface ahb_bus_mux_ctrl_if #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [MW-1:0]                 Hmaster;
  logic [NUM_MASTERS*ADDR_W-1:0] m_Haddr;
  logic [NUM_MASTERS*2-1:0]      m_Htrans;
  logic [NUM_MASTERS-1:0]        m_Hwrite;
  logic [NUM_MASTERS*3-1:0]      m_Hsize;
  logic [NUM_MASTERS*3-1:0]      m_Hburst;
  logic [NUM_MASTERS*DATA_W-1:0] m_Hwdata;
  logic [NUM_SLAVES*DATA_W-1:0]  s_Hrdata;
  logic [NUM_SLAVES-1:0]         s_Hreadyout;
  logic [NUM_SLAVES-1:0]         s_Hresp;

  logic [ADDR_W-1:0]             Haddr;
  logic [1:0]                    Htrans;
  logic                          Hwrite;
  logic [2:0]                    Hsize;
  logic [2:0]                    Hburst;
  logic [DATA_W-1:0]             Hwdata;
  logic [NUM_SLAVES-1:0]         Hsel;
  logic [DATA_W-1:0]             Hrdata;
  logic                          Hready;
  logic                          Hresp;
  logic [MW-1:0]                 Hmaster_data;
  logic [15:0]                   err_count;

  modport master (
    input  Hmaster, m_Haddr, m_Htrans, m_Hwrite, m_Hsize, m_Hburst, m_Hwdata,
           s_Hrdata, s_Hreadyout, s_Hresp,
    output Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata, Hsel, Hrdata,
           Hready, Hresp, Hmaster_data, err_count
  );

  modport slave (
    output Hmaster, m_Haddr, m_Htrans, m_Hwrite, m_Hsize, m_Hburst, m_Hwdata,
           s_Hrdata, s_Hreadyout, s_Hresp,
    input  Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata, Hsel, Hrdata,
           Hready, Hresp, Hmaster_data, err_count
  );
endinterface

// File: rtl/ahb_bus_mux_ctrl.sv
// rtl/ahb_bus_mux_ctrl.sv - AHB-Lite address/data-phase mux with default ERROR slave; AHB_MUX_ERR_CNT_EN adds error counter
module ahb_bus_mux_ctrl #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input logic                 Hclk,
  input logic                 Hresetn,
  ahb_bus_mux_ctrl_if.master  bus
);
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [4:0] UNMAPPED = 5'd16;

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

  ds_state_t             state_q, state_d;
  logic [MW-1:0]         hm_data_q;
  logic [4:0]            dsel_q;
  logic                  dact_q;
  logic [3:0]            top_nib;
  logic [NUM_SLAVES-1:0] hsel;
  logic                  unmapped;
  logic [4:0]            dec_idx;
  logic                  unm_acc;

  always_comb begin
    int mi;
    mi = int'(bus.Hmaster);
    bus.Haddr  = bus.m_Haddr[mi*ADDR_W +: ADDR_W];
    bus.Htrans = bus.m_Htrans[mi*2 +: 2];
    bus.Hwrite = bus.m_Hwrite[mi];
    bus.Hsize  = bus.m_Hsize[mi*3 +: 3];
    bus.Hburst = bus.m_Hburst[mi*3 +: 3];
  end

  // Decode ignores Htrans so slaves see a stable select through IDLE/BUSY.
  assign top_nib = bus.Haddr[ADDR_W-1 -: 4];

  always_comb begin
    hsel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hsel[i] = (top_nib == 4'(i));
    end
  end

  assign unmapped = ~|hsel;
  assign dec_idx  = unmapped ? UNMAPPED : {1'b0, top_nib};
  assign bus.Hsel = hsel;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      hm_data_q <= '0;
      dsel_q    <= UNMAPPED;
      dact_q    <= 1'b0;
    end else if (bus.Hready) begin
      hm_data_q <= bus.Hmaster;
      dsel_q    <= dec_idx;
      dact_q    <= bus.Htrans[1];
    end
  end

  assign unm_acc = bus.Hready && bus.Htrans[1] && unmapped;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) state_q <= DS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (unm_acc) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = unm_acc ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_comb begin
    int si;
    si         = int'(dsel_q[3:0]);
    bus.Hready = 1'b1;
    bus.Hresp  = 1'b0;
    bus.Hrdata = '0;
    if (dact_q) begin
      if (dsel_q != UNMAPPED) begin
        bus.Hready = bus.s_Hreadyout[si];
        bus.Hresp  = bus.s_Hresp[si];
        bus.Hrdata = bus.s_Hrdata[si*DATA_W +: DATA_W];
      end else begin
        bus.Hready = (state_q != DS_ERR1);
        bus.Hresp  = (state_q != DS_IDLE);
      end
    end
  end

  assign bus.Hwdata       = bus.m_Hwdata[int'(hm_data_q)*DATA_W +: DATA_W];
  assign bus.Hmaster_data = hm_data_q;

`ifdef AHB_MUX_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn)
      err_cnt_q <= '0;
    else if (state_q == DS_ERR1 && err_cnt_q != 16'hFFFF)
      err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ahb_bus_mux_ctrl.sv
// tb/tb_ahb_bus_mux_ctrl.sv - directed table and sequence checks for ahb_bus_mux_ctrl
module tb_ahb_bus_mux_ctrl;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
`ifdef AHB_MUX_ERR_CNT_EN
  localparam logic [15:0] ONE_ERR = 16'd1, THREE_ERR = 16'd3;
`else
  localparam logic [15:0] ONE_ERR = 16'd0, THREE_ERR = 16'd0;
`endif

  logic Hclk = 1'b0;
  logic Hresetn = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;

  always #5 Hclk = ~Hclk;

  ahb_bus_mux_ctrl_if #(.NUM_MASTERS(4), .NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32)) bus ();

  ahb_bus_mux_ctrl #(.NUM_MASTERS(4), .NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32)) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus)
  );

  typedef struct {
    int          hm;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [3:0]  exp_sel;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_m(input int k, input logic [31:0] addr, input logic [1:0] trans, input logic wr);
    bus.m_Haddr[k*32 +: 32] = addr;
    bus.m_Htrans[k*2 +: 2]  = trans;
    bus.m_Hwrite[k]         = wr;
  endtask

  task automatic step();
    @(posedge Hclk);
    #2;
  endtask

  initial begin
    vecs[0] = '{0, 32'h0000_0010, NONSEQ, 1'b0, 4'b0001};
    vecs[1] = '{1, 32'h1000_0004, SEQ,    1'b1, 4'b0010};
    vecs[2] = '{2, 32'h2ABC_0000, IDLE,   1'b0, 4'b0100};
    vecs[3] = '{3, 32'h3FFF_FFFC, BUSY,   1'b1, 4'b1000};
    vecs[4] = '{3, 32'h4000_0000, NONSEQ, 1'b0, 4'b0000};
    vecs[5] = '{0, 32'hF000_0000, SEQ,    1'b1, 4'b0000};

    bus.Hmaster     = '0;
    bus.m_Haddr     = '0;
    bus.m_Htrans    = '0;
    bus.m_Hwrite    = '0;
    bus.m_Hsize     = {3'd3, 3'd2, 3'd1, 3'd0};
    bus.m_Hburst    = {3'd4, 3'd5, 3'd6, 3'd7};
    bus.m_Hwdata    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    bus.s_Hrdata    = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};
    bus.s_Hreadyout = '1;
    bus.s_Hresp     = '0;
    #3;

    chk("rst_hready", 64'(bus.Hready), 64'd1);
    chk("rst_hresp", 64'(bus.Hresp), 64'd0);
    chk("rst_hrdata", 64'(bus.Hrdata), 64'd0);
    chk("rst_hmaster_data", 64'(bus.Hmaster_data), 64'd0);
    chk("rst_err_count", 64'(bus.err_count), 64'd0);

    // Address-phase mux/decode table, held in reset so nothing is accepted.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 4; k++) set_m(k, ~vecs[v].addr, ~vecs[v].trans, ~vecs[v].wr);
      set_m(vecs[v].hm, vecs[v].addr, vecs[v].trans, vecs[v].wr);
      bus.Hmaster = 2'(vecs[v].hm);
      #1;
      chk($sformatf("v%0d_haddr", v), 64'(bus.Haddr), 64'(vecs[v].addr));
      chk($sformatf("v%0d_hsel", v), 64'(bus.Hsel), 64'(vecs[v].exp_sel));
      chk($sformatf("v%0d_htrans", v), 64'(bus.Htrans), 64'(vecs[v].trans));
      chk($sformatf("v%0d_hwrite", v), 64'(bus.Hwrite), 64'(vecs[v].wr));
      chk($sformatf("v%0d_hsize", v), 64'(bus.Hsize), 64'(vecs[v].hm));
      chk($sformatf("v%0d_hburst", v), 64'(bus.Hburst), 64'(7 - vecs[v].hm));
    end

    for (int k = 0; k < 4; k++) set_m(k, 32'h0000_0000, IDLE, 1'b0);
    bus.Hmaster = 2'd0;
    step();
    Hresetn = 1'b1;
    step();

    // Mapped write: data-phase owner and write data follow one cycle later.
    bus.Hmaster = 2'd2;
    set_m(2, 32'h1000_0004, NONSEQ, 1'b1);
    #1;
    chk("wr_hsel", 64'(bus.Hsel), 64'b0010);
    step();
    set_m(2, 32'h1000_0004, IDLE, 1'b1);
    #1;
    chk("wr_hmaster_data", 64'(bus.Hmaster_data), 64'd2);
    chk("wr_hwdata", 64'(bus.Hwdata), 64'h2222_2222);
    chk("wr_hready", 64'(bus.Hready), 64'd1);

    // Slave 1 read with two wait states and an Hmaster change during the wait.
    bus.Hmaster = 2'd1;
    set_m(1, 32'h1000_0000, NONSEQ, 1'b0);
    step();
    set_m(1, 32'h1000_0000, IDLE, 1'b0);
    set_m(3, 32'h3000_0000, IDLE, 1'b0);
    bus.Hmaster = 2'd3;
    bus.s_Hreadyout[1] = 1'b0;
    #1;
    chk("rd_w1_hready", 64'(bus.Hready), 64'd0);
    chk("rd_w1_hmaster_data", 64'(bus.Hmaster_data), 64'd1);
    chk("rd_w1_haddr", 64'(bus.Haddr), 64'h3000_0000);
    step();
    #1;
    chk("rd_w2_hready", 64'(bus.Hready), 64'd0);
    chk("rd_w2_hmaster_data", 64'(bus.Hmaster_data), 64'd1);
    step();
    bus.s_Hreadyout[1] = 1'b1;
    bus.s_Hrdata[32 +: 32] = 32'hCAFE_F00D;
    #1;
    chk("rd_done_hready", 64'(bus.Hready), 64'd1);
    chk("rd_done_hrdata", 64'(bus.Hrdata), 64'hCAFE_F00D);
    chk("rd_done_hresp", 64'(bus.Hresp), 64'd0);
    chk("rd_done_hmaster_data", 64'(bus.Hmaster_data), 64'd1);
    step();
    #1;
    chk("rd_after_hmaster_data", 64'(bus.Hmaster_data), 64'd3);
    chk("rd_after_hrdata", 64'(bus.Hrdata), 64'd0);

    // Single unmapped NONSEQ: two-cycle ERROR response.
    bus.Hmaster = 2'd0;
    set_m(0, 32'hF000_0000, NONSEQ, 1'b0);
    #1;
    chk("err_hsel", 64'(bus.Hsel), 64'd0);
    step();
    set_m(0, 32'hF000_0000, IDLE, 1'b0);
    #1;
    chk("err1_hready", 64'(bus.Hready), 64'd0);
    chk("err1_hresp", 64'(bus.Hresp), 64'd1);
    step();
    #1;
    chk("err2_hready", 64'(bus.Hready), 64'd1);
    chk("err2_hresp", 64'(bus.Hresp), 64'd1);
    step();
    #1;
    chk("err_end_hready", 64'(bus.Hready), 64'd1);
    chk("err_end_hresp", 64'(bus.Hresp), 64'd0);
    chk("err_count_1", 64'(bus.err_count), 64'(ONE_ERR));

    // Back-to-back unmapped NONSEQs, then unmapped IDLE/BUSY is zero-wait OKAY.
    set_m(0, 32'hF000_0000, NONSEQ, 1'b0);
    step();
    #1;
    chk("b2b_a_err1", 64'({bus.Hready, bus.Hresp}), 64'b01);
    step();
    #1;
    chk("b2b_a_err2", 64'({bus.Hready, bus.Hresp}), 64'b11);
    step();
    set_m(0, 32'hF000_0000, IDLE, 1'b0);
    #1;
    chk("b2b_b_err1", 64'({bus.Hready, bus.Hresp}), 64'b01);
    step();
    #1;
    chk("b2b_b_err2", 64'({bus.Hready, bus.Hresp}), 64'b11);
    step();
    set_m(0, 32'hF000_0000, BUSY, 1'b0);
    #1;
    chk("b2b_idle_okay", 64'({bus.Hready, bus.Hresp}), 64'b10);
    step();
    set_m(0, 32'h0000_0000, IDLE, 1'b0);
    #1;
    chk("busy_unmapped_okay", 64'({bus.Hready, bus.Hresp}), 64'b10);
    chk("err_count_3", 64'(bus.err_count), 64'(THREE_ERR));

`ifdef AHB_MUX_ERR_CNT_EN
    // Preload near the top, then confirm saturation.
    dut.err_cnt_q = 16'hFFFD;
    for (int e = 0; e < 3; e++) begin
      set_m(0, 32'hF000_0000, NONSEQ, 1'b0);
      step();
      set_m(0, 32'hF000_0000, IDLE, 1'b0);
      step();
      step();
      #1;
      chk($sformatf("sat_%0d", e), 64'(bus.err_count), (e == 0) ? 64'hFFFE : 64'hFFFF);
    end
`endif

    // Reset asserted while a mapped slave is inserting wait states.
    bus.Hmaster = 2'd1;
    set_m(1, 32'h1000_0000, NONSEQ, 1'b0);
    step();
    set_m(1, 32'h1000_0000, IDLE, 1'b0);
    bus.s_Hreadyout[1] = 1'b0;
    bus.s_Hresp[1] = 1'b1;
    #1;
    chk("mid_pre_hready", 64'(bus.Hready), 64'd0);
    chk("mid_pre_hrdata", 64'(bus.Hrdata), 64'hCAFE_F00D);
    #1;
    Hresetn = 1'b0;
    #1;
    chk("mid_rst_hready", 64'(bus.Hready), 64'd1);
    chk("mid_rst_hresp", 64'(bus.Hresp), 64'd0);
    chk("mid_rst_hrdata", 64'(bus.Hrdata), 64'd0);
    chk("mid_rst_hmaster_data", 64'(bus.Hmaster_data), 64'd0);
    chk("mid_rst_err_count", 64'(bus.err_count), 64'd0);
    step();
    Hresetn = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
